counter: RTL and testbench
==========================

// Module: counter
// PURPOSE
//  - Generic synchronous binary up/down counter with clear, enable, parallel load and wrap flag.
//  - Free-running use: seven-segment display controller, WIDTH=20, clear=0, en=1, load=0, up_dn=0, d=0.
//  - There the top 3 bits of o_q select the active digit (8 digits, full scan every 2^20 cycles).
// PARAMETERS
//  - WIDTH       default 8   counter width in bits, legal range 2..32.
//  - LOAD_WIDTH  default 16  width of i_d.
// PORTS
//  - i_clk    in   1           clock; all state changes on rising edge.
//  - i_rst    in   1           asynchronous, active-high reset.
//  - i_clr    in   1           synchronous clear.
//  - i_en     in   1           count enable.
//  - i_load   in   1           synchronous parallel load.
//  - i_up_dn  in   1           direction: 0 = count up, 1 = count down.
//  - i_d      in   LOAD_WIDTH  load value.
//  - o_q      out  WIDTH       registered count.
//  - o_ovf    out  1           registered wrap flag.
// BEHAVIOUR
//  - Reset (async, any time, including mid-count): o_q=0, o_ovf=0 immediately, held while i_rst=1.
//  - Each rising edge when not in reset, strict priority i_clr > i_load > i_en:
//    - i_clr=1: o_q <= 0, o_ovf <= 0.
//    - else i_load=1: o_q <= i_d resized to WIDTH, o_ovf <= 0.
//      - Resize: zero-extend if LOAD_WIDTH < WIDTH, keep low WIDTH bits if LOAD_WIDTH > WIDTH.
//    - else i_en=1, up: o_q <= o_q+1 modulo 2^WIDTH.
//    - else i_en=1, down: o_q <= o_q-1 modulo 2^WIDTH.
//    - else: o_q holds, o_ovf <= 0.
//  - o_ovf is a one-cycle pulse, registered with the wrapping step:
//    - it is 1 in the cycle after an edge where up stepped 2^WIDTH-1 -> 0, or down stepped 0 -> 2^WIDTH-1;
//    - it is 0 after every other edge.
//  - Latency: every control input takes effect on the next edge. No combinational path from inputs to outputs.
//  - Consecutive wraps give consecutive pulses. i_up_dn may change on any cycle; the next step uses the new direction.
// CONFIGURATION
//  - Macro COUNTER_SATURATE_EN.
//  - Undefined (default): wrap-around behaviour as above.
//  - Defined: saturating counter.
//    - Up at 2^WIDTH-1, or down at 0: o_q holds and o_ovf <= 1.
//    - o_ovf stays 1 every cycle that i_en keeps pushing past the bound.
//    - clr/load/reset behaviour and priority unchanged.
// TESTING
//  - WIDTH=4, reset mid-count with o_q=5 -> o_q=0, o_ovf=0 without waiting for an edge.
//  - en=1, up: 16 edges from 0 -> o_q 0..15 then 0; o_ovf=1 for exactly the one cycle where o_q=0 after 15.
//  - load=1, d=16'h00A7, WIDTH=4 -> o_q=7. Then en=1, up_dn=1 for 8 edges -> o_q=15 after reaching 0, o_ovf pulse once.
//  - clr=1, load=1, en=1 together with o_q=9 -> o_q=0; load=1, en=1, d=3 -> o_q=3 (clear beats load, load beats enable).
//  - en=0 for 10 edges at o_q=6 -> o_q stays 6, o_ovf stays 0.
//  - COUNTER_SATURATE_EN, WIDTH=4, up from 14, 3 edges -> o_q=15,15,15; o_ovf=0,1,1.

Source files
------------

// File: rtl/counter.sv
// Up/down binary counter with synchronous clear, parallel load and a registered wrap flag.
// Define COUNTER_SATURATE_EN to make the count stick at its bounds instead of wrapping.
module counter #(
  parameter int WIDTH      = 8,
  parameter int LOAD_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic                  i_up_dn,
  input  logic [LOAD_WIDTH-1:0] i_d,
  output logic [WIDTH-1:0]      o_q,
  output logic                  o_ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_step;
  logic             w_at_bound;
  logic             w_unused_d;

  // Resize the load word: low bits pass through, bits beyond LOAD_WIDTH read as zero.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_load_bit
      if (gi < LOAD_WIDTH) begin : g_from_d
        assign w_load_val[gi] = i_d[gi];
      end else begin : g_zero
        assign w_load_val[gi] = 1'b0;
      end
    end
  endgenerate

  // Upper load bits are intentionally discarded when LOAD_WIDTH exceeds WIDTH.
  assign w_unused_d = ^i_d;

  assign w_at_bound = i_up_dn ? (r_q == '0) : (r_q == MAX_VAL);
  assign w_step     = i_up_dn ? (r_q - ONE_VAL) : (r_q + ONE_VAL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (i_load) begin
      r_q   <= w_load_val;
      r_ovf <= 1'b0;
    end else if (i_en) begin
`ifdef COUNTER_SATURATE_EN
      // Pushing past a bound holds the count and keeps the flag raised.
      if (w_at_bound) begin
        r_ovf <= 1'b1;
      end else begin
        r_q   <= w_step;
        r_ovf <= 1'b0;
      end
`else
      r_q   <= w_step;
      r_ovf <= w_at_bound;
`endif
    end else begin
      r_ovf <= 1'b0;
    end
  end

  assign o_q   = r_q;
  assign o_ovf = r_ovf;

endmodule

// File: tb/tb_counter.sv
// Directed-vector bench for counter at WIDTH=4, LOAD_WIDTH=16.
// Expected values follow the saturating variant when COUNTER_SATURATE_EN is defined.
module tb_counter;

  localparam int WIDTH      = 4;
  localparam int LOAD_WIDTH = 16;

  logic                  i_clk;
  logic                  i_rst;
  logic                  i_clr;
  logic                  i_en;
  logic                  i_load;
  logic                  i_up_dn;
  logic [LOAD_WIDTH-1:0] i_d;
  logic [WIDTH-1:0]      o_q;
  logic                  o_ovf;

  int n_tests;
  int n_fail;

  counter #(.WIDTH(WIDTH), .LOAD_WIDTH(LOAD_WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_clr),
    .i_en    (i_en),
    .i_load  (i_load),
    .i_up_dn (i_up_dn),
    .i_d     (i_d),
    .o_q     (o_q),
    .o_ovf   (o_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ctl(input logic clr, input logic load, input logic en,
                         input logic up_dn, input logic [LOAD_WIDTH-1:0] d);
    i_clr   = clr;
    i_load  = load;
    i_en    = en;
    i_up_dn = up_dn;
    i_d     = d;
  endtask

  task automatic do_load(input logic [LOAD_WIDTH-1:0] d);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, d);
    step();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #2;
    n_tests++;
    if (o_q !== 4'd0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: got q=%0d ovf=%b, want q=0 ovf=0", o_q, o_ovf);
    end
    step();
    i_rst = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if (o_q !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_precount: got q=%0d, want q=5", o_q);
    end
    // Assert reset mid-cycle and look before the next edge arrives.
    #2;
    i_rst = 1'b1;
    #1;
    n_tests++;
    if (o_q !== 4'd0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got q=%0d ovf=%b, want q=0 ovf=0", o_q, o_ovf);
    end
    step();
    n_tests++;
    if (o_q !== 4'd0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: got q=%0d ovf=%b, want q=0 ovf=0", o_q, o_ovf);
    end
    #2;
    i_rst = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    $display("[TB] reset: async clear mid-count checked");
  endtask

  task automatic test_wrap_up();
    logic [WIDTH-1:0] exp_q;
    logic             exp_ovf;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 16; i++) begin
      step();
`ifdef COUNTER_SATURATE_EN
      exp_q = (i > 15) ? 4'd15 : 4'(i);
`else
      exp_q = 4'(i % 16);
`endif
      exp_ovf = (i == 16);
      n_tests++;
      if (o_q !== exp_q || o_ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL wrap_up step %0d: got q=%0d ovf=%b, want q=%0d ovf=%b",
                 i, o_q, o_ovf, exp_q, exp_ovf);
      end
    end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    $display("[TB] wrap_up: 16 up steps from 0 checked");
  endtask

  task automatic test_load_down();
    logic [WIDTH-1:0] exp_q;
    logic             exp_ovf;
    int               pulses;
    do_load(16'h00A7);
    n_tests++;
    if (o_q !== 4'd7 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL load_resize: got q=%0d ovf=%b, want q=7 ovf=0", o_q, o_ovf);
    end
    pulses = 0;
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, '0);
    for (int k = 1; k <= 8; k++) begin
      step();
`ifdef COUNTER_SATURATE_EN
      exp_q = (k <= 7) ? 4'(7 - k) : 4'd0;
`else
      exp_q = (k <= 7) ? 4'(7 - k) : 4'd15;
`endif
      exp_ovf = (k == 8);
      if (o_ovf === 1'b1) pulses++;
      n_tests++;
      if (o_q !== exp_q || o_ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL load_down step %0d: got q=%0d ovf=%b, want q=%0d ovf=%b",
                 k, o_q, o_ovf, exp_q, exp_ovf);
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL load_down_pulses: got %0d pulses, want 1", pulses);
    end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    $display("[TB] load_down: load A7 then 8 down steps checked");
  endtask

  task automatic test_priority();
    do_load(16'd9);
    n_tests++;
    if (o_q !== 4'd9) begin
      n_fail++;
      $display("FAIL prio_preload: got q=%0d, want q=9", o_q);
    end
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 16'd3);
    step();
    n_tests++;
    if (o_q !== 4'd0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_clr: got q=%0d ovf=%b, want q=0 ovf=0", o_q, o_ovf);
    end
    set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 16'd3);
    step();
    n_tests++;
    if (o_q !== 4'd3 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_load: got q=%0d ovf=%b, want q=3 ovf=0", o_q, o_ovf);
    end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    $display("[TB] priority: clear > load > enable checked");
  endtask

  task automatic test_hold();
    do_load(16'd6);
    for (int i = 1; i <= 10; i++) begin
      step();
      n_tests++;
      if (o_q !== 4'd6 || o_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL hold step %0d: got q=%0d ovf=%b, want q=6 ovf=0", i, o_q, o_ovf);
      end
    end
    $display("[TB] hold: 10 idle edges at 6 checked");
  endtask

  task automatic test_back_to_back();
    logic             dirs [4];
    logic [WIDTH-1:0] exp_q [4];
    logic             exp_o [4];
    dirs = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef COUNTER_SATURATE_EN
    exp_q = '{4'd15, 4'd14, 4'd15, 4'd15};
    exp_o = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{4'd0, 4'd15, 4'd0, 4'd1};
    exp_o = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    do_load(16'd15);
    for (int i = 0; i < 4; i++) begin
      set_ctl(1'b0, 1'b0, 1'b1, dirs[i], '0);
      step();
      n_tests++;
      if (o_q !== exp_q[i] || o_ovf !== exp_o[i]) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got q=%0d ovf=%b, want q=%0d ovf=%b",
                 i, o_q, o_ovf, exp_q[i], exp_o[i]);
      end
    end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    $display("[TB] back_to_back: direction flips at bounds checked");
  endtask

  task automatic test_boundary();
    logic [WIDTH-1:0] exp_q [3];
    logic             exp_o [3];
`ifdef COUNTER_SATURATE_EN
    exp_q = '{4'd15, 4'd15, 4'd15};
    exp_o = '{1'b0, 1'b1, 1'b1};
`else
    exp_q = '{4'd15, 4'd0, 4'd1};
    exp_o = '{1'b0, 1'b1, 1'b0};
`endif
    do_load(16'd14);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (o_q !== exp_q[i] || o_ovf !== exp_o[i]) begin
        n_fail++;
        $display("FAIL boundary step %0d: got q=%0d ovf=%b, want q=%0d ovf=%b",
                 i, o_q, o_ovf, exp_q[i], exp_o[i]);
      end
    end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    n_tests++;
    if (o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_release: got ovf=%b, want ovf=0", o_ovf);
    end
    $display("[TB] boundary: up from 14 for 3 edges checked");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_wrap_up();
    test_load_down();
    test_priority();
    test_hold();
    test_back_to_back();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
